fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline, directly upstream of decode_stage. Owns the PC, issues
//  instruction reads on the SRAM-like inst bus (addr/data split handshake), holds one fetched
//  instruction for decode, applies delayed-branch redirects and exception/ERET flushes.
// PARAMETERS
//  RESET_PC  32'hBFC00000  PC after reset
//  EXC_ADEL  5'h04         exccode for misaligned fetch address
// PORTS
//  clk          in   1   clock, all flops posedge
//  resetn       in   1   asynchronous, active-low reset
//  inst_req     out  1   read request valid
//  inst_addr    out  32  read address (word aligned when issued)
//  inst_addr_ok in   1   address accepted this cycle
//  inst_data_ok in   1   read data returned this cycle (in request order)
//  inst_rdata   in   32  returned instruction
//  branch       in   1   decode redirect (fires only when decode hands branch to EX)
//  branch_pc    in   32  redirect target
//  branch_ack   out  1   delay slot is in flight or buffered; decode may resolve branch
//  flush        in   1   exception/ERET from WB; highest priority
//  flush_pc     in   32  handler / EPC target
//  ready_i      in   1   decode consumes valid_o this cycle (decode done_o && its ready_i)
//  valid_o      out  1   instruction slot valid
//  pc_o         out  32  PC of slot
//  inst_o       out  32  instruction of slot (0 when exc_o)
//  exc_o        out  1   slot carries fetch exception
//  exccode_o    out  5   EXC_ADEL when exc_o, else 0
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, inst_req=0, valid_o=0, pc_o/inst_o=0, exc_o=0, exccode_o=0,
//    outstanding=0, discard=0, branch_ack=0. First inst_req the cycle after reset releases.
//  - FSM: IDLE -> REQ (inst_req=1, hold addr until addr_ok) -> WAIT (data_ok) -> IDLE.
//    At most one outstanding read; new request only when slot empty or being consumed.
//  - Misaligned pc[1:0]!=0: no bus request; slot filled next cycle with exc_o=1, exccode_o=EXC_ADEL,
//    pc_o=pc; fetch then halts in IDLE until flush.
//  - data_ok in WAIT: if discard=1 drop data, clear discard; else fill slot, pc+=4.
//  - Slot: valid_o stays high with stable pc_o/inst_o until ready_i; consume+fill same cycle allowed.
//  - branch_ack = (valid_o slot pc == pc_o_decode+4 buffered) || (outstanding pc == that value);
//    i.e. delay slot already requested or held. Combinational from state, not from branch.
//  - branch: delay slot kept; any later sequential request marked discard (if addr already accepted)
//    or withdrawn (if still in REQ without addr_ok: inst_addr switches next cycle); pc=branch_pc.
//  - flush: valid_o=0, slot cleared, outstanding read marked discard, REQ withdrawn, pc=flush_pc,
//    halt state exited. flush overrides branch and ready_i in the same cycle.
//  - flush/branch while REQ and addr_ok same cycle: request counts as accepted, marked discard.
//  - Wrap: pc 32'hFFFFFFFC + 4 wraps to 0, no exception.
//  - No combinational path from inst_rdata to inst_req; inst_addr driven only from pc flop.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (slots filled) and
//   perf_discard_cnt[31:0] (responses dropped), reset 0, wrap at 2^32, frozen never.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset release, addr_ok/data_ok 1 cycle each, ready_i=1 -> pcs BFC00000,BFC00004,... on pc_o.
//  2 ready_i=0 for 5 cycles with slot full -> pc_o/inst_o stable, no further inst_req.
//  3 Decode branch at pc 100, delay slot 104 outstanding, branch_pc=200 -> slot 104 delivered,
//    next inst_addr=200, 108 never reaches valid_o.
//  4 flush_pc=BFC00380 while read outstanding -> stale data_ok dropped, next valid_o pc_o=BFC00380.
//  5 branch_pc=202 -> after delay slot, valid_o with exc_o=1, exccode_o=04, pc_o=202, no inst_req.
//  6 resetn low mid-WAIT -> all outputs to reset values immediately; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage that owns the PC, issues reads on the split addr/data inst bus and holds one slot for decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_discard_cnt outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [4:0]  EXC_ADEL = 5'h04
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    output logic        branch_ack,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    // state  | meaning
    // S_IDLE | no bus activity; waits for a free slot (or halted after a fetch exception)
    // S_REQ  | inst_req high, inst_addr held from r_pc until inst_addr_ok
    // S_WAIT | one read accepted, waiting for inst_data_ok
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_out_pc;
    logic        r_discard;
    logic        r_halt;

    logic        r_valid;
    logic [31:0] r_slot_pc;
    logic [31:0] r_inst;
    logic        r_exc;

    logic        r_dec_valid;
    logic [31:0] r_dec_pc;

    logic        w_consume;
    logic        w_slot_free;
    logic [31:0] w_ds_pc;
    logic        w_out_is_ds;
    logic        w_accept;
    logic        w_fill;
    logic        w_exc_fill;
    logic        w_discard_nxt;

    assign w_consume   = r_valid && ready_i;
    assign w_slot_free = !r_valid || ready_i;

    // Delay slot of the branch decode currently holds (the last instruction it consumed).
    assign w_ds_pc     = r_dec_pc + 32'd4;
    assign w_out_is_ds = r_dec_valid && (r_out_pc == w_ds_pc);

    assign inst_req    = (r_state == S_REQ);
    assign inst_addr   = r_pc;

    assign branch_ack  = r_dec_valid &&
                         ((r_valid && (r_slot_pc == w_ds_pc)) ||
                          ((r_state == S_WAIT) && !r_discard && (r_out_pc == w_ds_pc)));

    assign valid_o     = r_valid;
    assign pc_o        = r_slot_pc;
    assign inst_o      = r_inst;
    assign exc_o       = r_exc;
    assign exccode_o   = r_exc ? EXC_ADEL : 5'h00;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_fill        = 1'b0;
        w_exc_fill    = 1'b0;
        w_discard_nxt = r_discard;
        case (r_state)
            S_IDLE: begin
                // A redirect this cycle makes r_pc stale, so nothing is started until it lands.
                if (!flush && !branch && !r_halt && w_slot_free) begin
                    if (r_pc[1:0] != 2'b00) begin
                        w_exc_fill = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (inst_addr_ok) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = S_WAIT;
                    w_discard_nxt = flush || branch;
                end else if (flush || branch) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    w_state_nxt   = S_IDLE;
                    w_discard_nxt = 1'b0;
                    w_fill        = !r_discard && !flush && !(branch && !w_out_is_ds);
                end else if (flush || (branch && !w_out_is_ds)) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_out_pc  <= 32'h0;
            r_discard <= 1'b0;
            r_halt    <= 1'b0;
        end else begin
            r_discard <= w_discard_nxt;
            if (flush) begin
                r_pc <= flush_pc;
            end else if (branch) begin
                r_pc <= branch_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_accept) begin
                r_out_pc <= r_pc;
            end
            if (flush) begin
                r_halt <= 1'b0;
            end else if (w_exc_fill) begin
                r_halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_slot_pc <= 32'h0;
            r_inst    <= 32'h0;
            r_exc     <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_slot_pc <= 32'h0;
            r_inst    <= 32'h0;
            r_exc     <= 1'b0;
        end else if (w_fill) begin
            r_valid   <= 1'b1;
            r_slot_pc <= r_out_pc;
            r_inst    <= inst_rdata;
            r_exc     <= 1'b0;
        end else if (w_exc_fill) begin
            r_valid   <= 1'b1;
            r_slot_pc <= r_pc;
            r_inst    <= 32'h0;
            r_exc     <= 1'b1;
        end else if (w_consume) begin
            r_valid   <= 1'b0;
        end
    end

    // Decode's current instruction, needed to locate its delay slot for branch_ack.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dec_valid <= 1'b0;
            r_dec_pc    <= 32'h0;
        end else if (flush) begin
            r_dec_valid <= 1'b0;
        end else if (w_consume) begin
            r_dec_valid <= 1'b1;
            r_dec_pc    <= r_slot_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_discard_cnt;
    logic        w_dropped;

    assign w_dropped = (r_state == S_WAIT) && inst_data_ok && !w_fill;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_fetch_cnt   <= 32'h0;
            r_perf_discard_cnt <= 32'h0;
        end else begin
            if (w_fill || w_exc_fill) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_dropped) begin
                r_perf_discard_cnt <= r_perf_discard_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt   = r_perf_fetch_cnt;
    assign perf_discard_cnt = r_perf_discard_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random bus/decode stimulus for fetch_stage, checked against a program-order PC model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_ADEL = 5'h04;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        branch = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic        branch_ack;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic [4:0]  exccode_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .EXC_ADEL(EXC_ADEL)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .branch       (branch),
        .branch_pc    (branch_pc),
        .branch_ack   (branch_ack),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .exc_o        (exc_o),
        .exccode_o    (exccode_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF4;
        else t = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
        if ($urandom_range(0, 4) == 0) t = t + 32'd2;
        return t;
    endfunction

    // Program-order model: next PC decode must see, pending delayed redirect, decode's held instruction.
    logic [31:0] exp_pc = RESET_PC;
    logic        armed = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        held_valid = 1'b0;
    logic        held_br = 1'b0;
    logic        held_exc = 1'b0;
    logic [31:0] held_tgt = 32'h0;
    int          idle_cnt = 0;

    logic [31:0] rsp_addr[$];
    int          rsp_lat[$];

    int p_aok, max_lat, p_ready, p_release, p_branch, p_flush_pm;

    task automatic model_reset();
        exp_pc = RESET_PC;
        armed = 1'b0;
        held_valid = 1'b0;
        idle_cnt = 0;
        rsp_addr.delete();
        rsp_lat.delete();
    endtask

    task automatic set_knobs(input int aok, input int lat, input int rdy, input int rel,
                             input int br, input int fl);
        p_aok = aok; max_lat = lat; p_ready = rdy; p_release = rel; p_branch = br; p_flush_pm = fl;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req"},     32'(inst_req), 32'h0);
        check_val({tag, "_addr"},    inst_addr, RESET_PC);
        check_val({tag, "_valid"},   32'(valid_o), 32'h0);
        check_val({tag, "_pc"},      pc_o, 32'h0);
        check_val({tag, "_inst"},    inst_o, 32'h0);
        check_val({tag, "_exc"},     32'(exc_o), 32'h0);
        check_val({tag, "_code"},    32'(exccode_o), 32'h0);
        check_val({tag, "_brack"},   32'(branch_ack), 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_val("first_req", 32'(inst_req), 32'h1);
        check_val("first_addr", inst_addr, RESET_PC);
    endtask

    task automatic step();
        logic exp_exc;
        logic do_flush;
        logic rel;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        branch       = 1'b0;
        branch_pc    = $urandom;
        flush        = 1'b0;
        flush_pc     = $urandom;
        ready_i      = 1'b0;
        idle_cnt++;

        if (inst_req) check_val("req_align", 32'(inst_addr[1:0]), 32'h0);
        if (held_valid && held_exc) check_val("halt_no_req", 32'(inst_req), 32'h0);

        exp_exc = (exp_pc[1:0] != 2'b00);
        if (valid_o) begin
            check_val("slot_pc", pc_o, exp_pc);
            check_val("slot_inst", inst_o, exp_exc ? 32'h0 : mem_f(exp_pc));
            check_val("slot_exc", 32'(exc_o), 32'(exp_exc));
            check_val("slot_code", 32'(exccode_o), exp_exc ? 32'(EXC_ADEL) : 32'h0);
        end

        if (rsp_addr.size() > 0) begin
            if (rsp_lat[0] == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_f(rsp_addr[0]);
                void'(rsp_addr.pop_front());
                void'(rsp_lat.pop_front());
            end else begin
                rsp_lat[0] = rsp_lat[0] - 1;
            end
        end
        if (inst_req && ($urandom_range(0, 99) < p_aok)) begin
            inst_addr_ok = 1'b1;
            rsp_addr.push_back(inst_addr);
            rsp_lat.push_back(int'($urandom_range(0, max_lat)));
        end

        if (held_valid && held_exc) do_flush = ($urandom_range(0, 3) == 0);
        else do_flush = ($urandom_range(0, 999) < p_flush_pm);

        if (do_flush) begin
            flush      = 1'b1;
            flush_pc   = rand_target();
            branch     = 1'($urandom_range(0, 1));
            ready_i    = 1'($urandom_range(0, 1));
            exp_pc     = flush_pc;
            armed      = 1'b0;
            held_valid = 1'b0;
            idle_cnt   = 0;
        end else begin
            rel = 1'b0;
            if (held_valid && held_br) begin
                if (branch_ack && ($urandom_range(0, 1) == 1)) begin
                    branch    = 1'b1;
                    branch_pc = held_tgt;
                    armed     = 1'b1;
                    tgt       = held_tgt;
                    rel       = 1'b1;
                end
            end else if (held_valid && !held_exc && ($urandom_range(0, 99) < p_release)) begin
                rel = 1'b1;
            end
            if (rel) held_valid = 1'b0;
            if (!held_valid && valid_o && ($urandom_range(0, 99) < p_ready)) begin
                ready_i    = 1'b1;
                held_valid = 1'b1;
                held_exc   = exp_exc;
                held_br    = !exp_exc && !armed && ($urandom_range(0, 99) < p_branch);
                held_tgt   = rand_target();
                if (armed) begin
                    exp_pc = tgt;
                    armed  = 1'b0;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
                idle_cnt = 0;
            end
        end
    endtask

    initial begin
        logic got;
        logic stuck;
        model_reset();
        set_knobs(100, 0, 100, 100, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        release_reset();

        // Full-speed bus, decode always ready: sequential PCs from RESET_PC.
        repeat (40) step();

        // Decode stalls with the slot full: slot stays put, no new request.
        set_knobs(100, 0, 0, 100, 0, 0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_o) begin
                got = 1'b1;
                break;
            end
        end
        check_val("stall_fill", 32'(got), 32'h1);
        repeat (5) begin
            step();
            check_val("stall_no_req", 32'(inst_req), 32'h0);
            check_val("stall_valid", 32'(valid_o), 32'h1);
        end

        // Random bus latency, decode stalls, branches (some misaligned targets) and flushes.
        set_knobs(60, 3, 70, 60, 30, 15);
        stuck = 1'b0;
        for (int i = 0; i < 5000 && !stuck; i++) begin
            step();
            if (idle_cnt > 400) begin
                check_val("progress", 32'(idle_cnt), 32'h0);
                stuck = 1'b1;
            end
        end

        // Asynchronous reset while a read is outstanding.
        set_knobs(100, 3, 100, 100, 0, 0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (inst_addr_ok) begin
                got = 1'b1;
                break;
            end
        end
        check_val("reach_wait", 32'(got), 32'h1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        branch = 1'b0;
        flush = 1'b0;
        ready_i = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
        set_knobs(100, 0, 100, 100, 0, 0);
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
